// File: rtl/miss_handler.sv
// -----------------------------------------------------------------------------
// miss_handler
//
// Cache-miss responder for the pipeline hazard unit. It takes one I-cache
// (f_cmiss) or D-cache (m_cmiss) miss at a time, D first. It fetches the whole
// line from the memory port and streams each beat into the owning cache. When
// the line is complete it pulses f_arrival or m_arrival for one cycle, which
// releases the stall.
//
// Ports
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   f_cmiss, f_addr     fetch miss request and byte address (held until arrival)
//   f_cancel            fetch miss withdrawn; the line still fills, arrival is dropped
//   m_cmiss, m_addr     data miss request and byte address (held until arrival)
//   mem_req, mem_addr   line read request, line-aligned address
//   mem_gnt             memory accepted the request
//   mem_rvalid/rdata    read beats, one word per valid cycle
//   rf_we_i, rf_we_d    refill write strobe into the I- or D-cache
//   rf_addr, rf_data    refill word byte address and data
//   f_arrival           fetch miss serviced, one-cycle pulse
//   m_arrival           data miss serviced, one-cycle pulse
//   busy                refill in progress (any state but IDLE)
// -----------------------------------------------------------------------------
module miss_handler #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              f_cmiss,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_cancel,
    input  logic              m_cmiss,
    input  logic [ADDR_W-1:0] m_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we_i,
    output logic              rf_we_d,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              f_arrival,
    output logic              m_arrival,
    output logic              busy
);

    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int BYTE_OFF_W = $clog2(DATA_W / 8);
    // Byte-offset bits inside one line; cleared to form the line base address.
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BEAT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_is_d_q, src_is_d_d;  // 1: serving D-cache, 0: I-cache
    logic              cancel_q, cancel_d;      // fetch miss withdrawn mid-refill
    logic [ADDR_W-1:0] base_q, base_d;
    logic              mem_req_q, busy_q, f_arrival_q, m_arrival_q;
    logic              beat_we;

    // NOTE: every variable gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_is_d_d = src_is_d_q;
        cancel_d   = cancel_q;
        base_d     = base_q;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                cancel_d = 1'b0;
                if (m_cmiss) begin
                    src_is_d_d = 1'b1;
                    base_d     = m_addr & ~LINE_MASK;
                    state_d    = REQ;
                end else if (f_cmiss) begin
                    src_is_d_d = 1'b0;
                    base_d     = f_addr & ~LINE_MASK;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = BEAT;
                end
            end
            BEAT: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + CNT_W'(1);  // wraps to 0 after the last beat
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A cancelled fetch still fills the line (the data is valid), only
        // the arrival pulse is withheld. Cancels for a D refill are ignored.
        if (f_cancel && (state_q != IDLE) && !src_is_d_q) begin
            cancel_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_is_d_q  <= 1'b0;
            cancel_q    <= 1'b0;
            base_q      <= '0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            f_arrival_q <= 1'b0;
            m_arrival_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_is_d_q  <= src_is_d_d;
            cancel_q    <= cancel_d;
            base_q      <= base_d;
            // Outputs are registered from the next state so they are glitch-free
            // and drop immediately with reset.
            mem_req_q   <= (state_d == REQ);
            busy_q      <= (state_d != IDLE);
            m_arrival_q <= (state_d == DONE) && src_is_d_d;
            f_arrival_q <= (state_d == DONE) && !src_is_d_d && !cancel_d;
        end
    end

    // Refill writes follow mem_rvalid in the same cycle.
    assign beat_we   = (state_q == BEAT) && mem_rvalid;
    assign rf_we_d   = beat_we && src_is_d_q;
    assign rf_we_i   = beat_we && !src_is_d_q;
    assign rf_addr   = beat_we ? base_q + (ADDR_W'(cnt_q) << BYTE_OFF_W) : '0;
    assign rf_data   = beat_we ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_req_q ? base_q : '0;
    assign busy      = busy_q;
    assign f_arrival = f_arrival_q;
    assign m_arrival = m_arrival_q;

endmodule

// File: tb/tb_miss_handler.sv
// -----------------------------------------------------------------------------
// tb_miss_handler
//
// The bench plays both cache requesters and the memory. Each refill is
// described at the transaction level: which cache misses, where, how long the
// memory stalls and what data it returns. From that description the bench
// derives, cycle by cycle, what the handler must show: the line-aligned
// request, the write into the owning cache at base + 4*k, and which arrival
// pulse follows. Stray gnt/rvalid pulses are injected wherever they must be
// ignored.
// -----------------------------------------------------------------------------
module tb_miss_handler;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              f_cmiss, f_cancel, m_cmiss;
    logic [ADDR_W-1:0] f_addr, m_addr;
    logic              mem_req, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr, rf_addr;
    logic [DATA_W-1:0] mem_rdata, rf_data;
    logic              rf_we_i, rf_we_d, f_arrival, m_arrival, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    miss_handler #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .f_cmiss    (f_cmiss),
        .f_addr     (f_addr),
        .f_cancel   (f_cancel),
        .m_cmiss    (m_cmiss),
        .m_addr     (m_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we_i    (rf_we_i),
        .rf_we_d    (rf_we_d),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .f_arrival  (f_arrival),
        .m_arrival  (m_arrival),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Called right after the inputs of a cycle are driven (at the falling
    // edge); samples 1 time unit later, well away from the rising edge.
    task automatic expect_cycle(input string tag, input bit e_req, input logic [31:0] e_maddr,
                                input bit e_wi, input bit e_wd, input logic [31:0] e_waddr,
                                input logic [31:0] e_wdata, input bit e_fa, input bit e_ma,
                                input bit e_busy);
        #1;
        check({tag, ".mem_req"}, mem_req, e_req);
        if (e_req) check({tag, ".mem_addr"}, mem_addr, e_maddr);
        check({tag, ".rf_we_i"}, rf_we_i, e_wi);
        check({tag, ".rf_we_d"}, rf_we_d, e_wd);
        if (e_wi || e_wd) begin
            check({tag, ".rf_addr"}, rf_addr, e_waddr);
            check({tag, ".rf_data"}, rf_data, e_wdata);
        end
        check({tag, ".f_arrival"}, f_arrival, e_fa);
        check({tag, ".m_arrival"}, m_arrival, e_ma);
        check({tag, ".busy"}, busy, e_busy);
    endtask

    // An idle cycle with random bus noise; nothing may happen.
    task automatic idle_cycle(input bit cancel_pulse);
        @(negedge clk);
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        f_cancel   = cancel_pulse;
        expect_cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        f_cancel = 1'b0;
    endtask

    // One complete line refill, starting with the IDLE cycle in which the
    // handler accepts the miss. gaps[2k+:2] idle memory cycles precede beat k.
    task automatic serve(input bit is_d, input int gnt_wait, input logic [7:0] gaps,
                         input bit do_cancel_in, input int cancel_k, input bit fixed_data,
                         input bit raise_m, input bit raise_f);
        logic [31:0] base;
        logic [31:0] data;
        bit          do_cancel;
        bit          drop_f;

        // Accepting IDLE cycle
        @(negedge clk);
        if (raise_m) m_cmiss = 1'b1;
        if (raise_f) f_cmiss = 1'b1;
        f_cancel   = 1'b0;
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        base       = (is_d ? m_addr : f_addr) & ~32'hF;
        // A cancel during a D refill is only issued when no fetch miss waits.
        do_cancel  = do_cancel_in && !(is_d && f_cmiss);
        drop_f     = 1'b0;
        expect_cycle("accept", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Request held until the memory grants it
        for (int w = 0; w <= gnt_wait; w++) begin
            @(negedge clk);
            mem_gnt    = (w == gnt_wait);
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            expect_cycle("req", 1, base, 0, 0, 0, 0, 0, 0, 1);
        end

        // Beats, each possibly preceded by memory wait cycles
        for (int k = 0; k < LINE_WORDS; k++) begin
            for (int g = 0; g < int'(gaps[2*k +: 2]); g++) begin
                @(negedge clk);
                f_cancel = 1'b0;
                if (drop_f) f_cmiss = 1'b0;
                mem_gnt    = 1'($urandom);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                expect_cycle("gap", 0, 0, 0, 0, 0, 0, 0, 0, 1);
            end
            @(negedge clk);
            f_cancel = 1'b0;
            if (drop_f) f_cmiss = 1'b0;
            data       = fixed_data ? 32'(32'hA0 + k) : $urandom;
            mem_gnt    = 1'($urandom);
            mem_rvalid = 1'b1;
            mem_rdata  = data;
            if (do_cancel && (k == cancel_k)) begin
                f_cancel = 1'b1;
                drop_f   = !is_d;  // the fetch side withdraws its miss
            end
            expect_cycle("beat", 0, 0, !is_d, is_d, 32'(base + 32'(k * 4)), data, 0, 0, 1);
        end

        // Completion cycle: the arrival pulse for the owning side
        @(negedge clk);
        f_cancel = 1'b0;
        if (drop_f) f_cmiss = 1'b0;
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        expect_cycle("done", 0, 0, 0, 0, 0, 0, !is_d && !do_cancel, is_d, 1);
        if (is_d) m_cmiss = 1'b0;
        else      f_cmiss = 1'b0;
    endtask

    initial begin
        logic [1:0] sel;

        rstn       = 1'b0;
        f_cmiss    = 1'b0;
        f_cancel   = 1'b0;
        m_cmiss    = 1'b0;
        f_addr     = '0;
        m_addr     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset state
        @(negedge clk);
        expect_cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single D miss, zero-wait memory, data A0..A3
        m_addr = 32'h0000_1238;
        serve(1, 0, 8'h00, 0, 0, 1, 1, 0);
        idle_cycle(0);

        // Simultaneous misses: D (0x80) first, then I (0x40)
        m_addr = 32'h0000_0080;
        f_addr = 32'h0000_0040;
        serve(1, 0, 8'h00, 0, 0, 0, 1, 1);
        serve(0, 0, 8'h00, 0, 0, 0, 0, 0);
        idle_cycle(0);

        // Bus wait states: gnt after 3 cycles, one gap before the third beat
        m_addr = 32'h0000_5A5C;
        serve(1, 3, 8'h10, 0, 0, 0, 1, 0);
        idle_cycle(0);

        // Cancelled fetch miss at 0x100, then a cancel pulse while idle
        f_addr = 32'h0000_0100;
        serve(0, 0, 8'h00, 1, 1, 0, 0, 1);
        idle_cycle(1);
        f_addr = 32'h0000_0204;
        serve(0, 1, 8'h00, 0, 0, 0, 0, 1);
        idle_cycle(0);

        // Reset in the middle of a refill, after two beats
        m_addr = 32'h2000_0014;
        @(negedge clk);
        m_cmiss    = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        expect_cycle("rst_accept", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        mem_gnt = 1'b1;
        expect_cycle("rst_req", 1, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hC0DE_0000 + 32'(k);
            expect_cycle("rst_beat", 0, 0, 0, 1, 32'(32'h2000_0010 + 32'(k * 4)),
                         32'hC0DE_0000 + 32'(k), 0, 0, 1);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        rstn       = 1'b0;
        expect_cycle("rst_abort", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            expect_cycle("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        rstn       = 1'b1;
        mem_rvalid = 1'b0;
        // m_cmiss is still high: a fresh refill from beat 0
        serve(1, 0, 8'h00, 0, 0, 0, 0, 0);
        idle_cycle(0);

        // Stray bus activity while idle, then a refill that must start clean
        repeat (4) begin
            @(negedge clk);
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            expect_cycle("stray", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        m_addr = 32'h0000_0F00;
        serve(1, 0, 8'h00, 0, 0, 0, 1, 0);
        idle_cycle(0);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            sel    = 2'($urandom_range(1, 3));
            m_addr = $urandom;
            f_addr = $urandom;
            if (sel[1]) begin
                serve(1, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3), 0, 1, sel[0]);
            end
            if (sel[0]) begin
                serve(0, $urandom_range(0, 3), 8'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3), 0, 0, !sel[1]);
            end
            idle_cycle($urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miss_handler.md
Name: miss_handler

Overview:
Cache-miss responder for the pipeline hazard unit. It accepts fetch-side (f_cmiss) and memory-side (m_cmiss) miss requests, refills one cache line from the memory bus, and returns single-cycle f_arrival / m_arrival pulses that release the hazard unit's stalls. It sits between the I/D caches, the hazard unit and the external memory port.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, memory beat / cache word width
LINE_WORDS, 4, words per cache line (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
f_cmiss  in  1  I-cache miss, held high by requester until f_arrival
f_addr  in  ADDR_W  fetch miss byte address
f_cancel  in  1  fetch miss cancelled (branch/flush), single-cycle pulse
m_cmiss  in  1  D-cache miss, held high until m_arrival
m_addr  in  ADDR_W  data miss byte address
mem_req  out  1  memory line-read request
mem_addr  out  ADDR_W  line-aligned request address
mem_gnt  in  1  memory accepts request
mem_rvalid  in  1  read beat valid
mem_rdata  in  DATA_W  read beat data
rf_we_i  out  1  I-cache refill write enable
rf_we_d  out  1  D-cache refill write enable
rf_addr  out  ADDR_W  refill word byte address
rf_data  out  DATA_W  refill word data
f_arrival  out  1  fetch miss serviced, 1-cycle pulse
m_arrival  out  1  data miss serviced, 1-cycle pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; beat counter 0; source and cancel flags cleared. Reset mid-refill aborts immediately: mem_req drops asynchronously and no arrival is issued.
- States: IDLE, REQ, BEAT, DONE. All state, counter and flag updates are registered.
- IDLE: m_cmiss has priority over f_cmiss. On the accepting edge, latch the source (D or I) and base = addr with its low log2(LINE_WORDS*DATA_W/8) bits cleared; go to REQ. No request -> stay in IDLE.
- REQ: mem_req=1, mem_addr=base, both held stable until mem_gnt; on mem_gnt go to BEAT with counter=0.
- BEAT: on each mem_rvalid, assert rf_we_d (source D) or rf_we_i (source I) combinationally for that cycle. rf_addr = base + counter*(DATA_W/8), rf_data = mem_rdata; counter increments. On the rvalid with counter==LINE_WORDS-1, go to DONE. Cycles without rvalid produce no write.
- DONE: pulse m_arrival (source D), or f_arrival (source I, cancel flag clear), for exactly this cycle; then return to IDLE.
- mem_rvalid outside BEAT is ignored. mem_gnt outside REQ is ignored.
- f_cancel while busy and source I: sets the cancel flag. The line still fills completely (line is valid data); f_arrival is suppressed.
- f_cancel in IDLE, or while serving D: ignored.
- Simultaneous misses: D is served first. f_cmiss stays high and is accepted in the first IDLE cycle after DONE.
- Requester contract: the line is written before DONE, so cmiss is low in the IDLE cycle following arrival; no double service occurs.
- Counter width: log2(LINE_WORDS); it wraps to 0 at line end.
- Minimum latency, zero-wait memory (gnt in REQ, rvalid every BEAT cycle): accept at edge 0, arrival in cycle LINE_WORDS+2 after the request.

Test Plan:
- Single D miss: m_cmiss=1, m_addr=0x0000_1238, immediate gnt, 4 back-to-back rvalid with data 0xA0..0xA3 -> mem_addr=0x0000_1230; rf_we_d writes 0x1230/0x1234/0x1238/0x123C with 0xA0..0xA3; m_arrival pulses 1 cycle, 6 cycles after accept; rf_we_i never asserted.
- Simultaneous misses: f_cmiss and m_cmiss both high, f_addr=0x40, m_addr=0x80 -> first mem_addr=0x80 with m_arrival; then mem_addr=0x40 with rf_we_i writes and f_arrival; arrivals never overlap.
- Bus wait states: gnt delayed 3 cycles, one idle gap between rvalid beats 2 and 3 -> mem_req/mem_addr stable for 4 cycles; exactly 4 refill writes at correct addresses; single arrival pulse.
- Cancel: f miss at 0x100, f_cancel pulsed during BEAT -> all 4 rf_we_i writes occur, f_arrival stays 0, busy falls after DONE. f_cancel in IDLE has no effect.
- Reset mid-operation: rstn=0 during BEAT after 2 beats -> mem_req, rf_we_*, busy go 0 immediately; no arrival; after release with m_cmiss still high, a fresh full refill starts from beat 0.
- Stray bus signals: rvalid/gnt pulses while IDLE -> no writes, no state change.
